pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/ret_addr_stack.sv | 60 ++++++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared op encodings and default parameter values for the PC sequencer and its return-address stack.
package pc_seq_pkg;

    localparam int unsigned PC_DEF_WIDTH        = 32;
    localparam int unsigned PC_DEF_STEP         = 1;
    localparam int unsigned PC_DEF_RESET_VECTOR = 0;
    localparam int unsigned PC_DEF_RAS_DEPTH    = 4;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_BR   = 3'b001,
        OP_JMP  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } pc_op_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry and pulses ovf_o.
module ret_addr_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = PC_DEF_WIDTH,
    parameter int DEPTH = PC_DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    // ptr_q is the next write slot; once full it also points at the oldest entry.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign top_o   = mem_q[ptr_q - PW'(1)];
    assign ovf_o   = ovf_q;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        if (push_i) begin
            ptr_d = ptr_q + PW'(1);
            ovf_d = full_o;
            if (!full_o) count_d = count_q + CW'(1);
        end else if (pop_i && !empty_o) begin
            ptr_d   = ptr_q - PW'(1);
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push_i) mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: SEQ/BR/JMP/CALL/RET next-PC selection with a return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = PC_DEF_WIDTH,
    parameter logic [WIDTH-1:0] STEP         = WIDTH'(PC_DEF_STEP),
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_DEF_RESET_VECTOR),
    parameter int               RAS_DEPTH    = PC_DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             take,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] pcOut,
    output logic [WIDTH-1:0] pc_next,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf,
    output logic             illegal_op
);

    logic [WIDTH-1:0] pc_q, pc_d, seq_pc, ras_top;
    logic             push, pop;
    logic             unf_q, unf_d, ill_q, ill_d;

    ret_addr_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (seq_pc),
        .top_o       (ras_top),
        .full_o      (ras_full),
        .empty_o     (ras_empty),
        .ovf_o       (ras_ovf)
    );

    assign seq_pc = pc_q + STEP;

    // en is a one-cycle advance strobe with no back-pressure: every cycle with en=1 consumes op.
    always_comb begin
        pc_d  = pc_q;
        push  = 1'b0;
        pop   = 1'b0;
        unf_d = 1'b0;
        ill_d = 1'b0;
        if (en) begin
            case (op)
                OP_SEQ:  pc_d = seq_pc;
                OP_BR:   pc_d = take ? (pc_q + operand) : seq_pc;
                OP_JMP:  pc_d = operand;
                OP_CALL: begin
                    push = 1'b1;
                    pc_d = operand;
                end
                OP_RET: begin
                    if (!ras_empty) begin
                        pop  = 1'b1;
                        pc_d = ras_top;
                    end else begin
                        pc_d  = seq_pc;
                        unf_d = 1'b1;
                    end
                end
                default: begin
                    pc_d  = seq_pc;
                    ill_d = 1'b1;
                end
            endcase
        end
    end

    assign pc_next    = rst ? RESET_VECTOR : pc_d;
    assign pcOut      = pc_q;
    assign ras_unf    = unf_q;
    assign illegal_op = ill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VECTOR;
            unf_q <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            unf_q <= unf_d;
            ill_q <= ill_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver queues hand-computed expectations, monitor checks after each edge.
module tb_pc_sequencer;

    localparam int W  = 32;
    localparam int EW = W + 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   op = 3'b000;
    logic         take = 1'b0;
    logic [W-1:0] operand = '0;
    logic [W-1:0] pcOut, pc_next;
    logic         ras_empty, ras_full, ras_ovf, ras_unf, illegal_op;

    int checks = 0;
    int errors = 0;

    // expected {pc, empty, full, ovf, unf, illegal} after the next edge
    logic [EW-1:0] exp_q[$];
    string         name_q[$];

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .op         (op),
        .take       (take),
        .operand    (operand),
        .pcOut      (pcOut),
        .pc_next    (pc_next),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the coming edge.
    task automatic drive(input logic r, input logic e, input logic [2:0] o, input logic t,
                         input logic [W-1:0] opd, input logic [W-1:0] xpc,
                         input logic xe, input logic xf, input logic xo, input logic xu,
                         input logic xi, input string nm);
        @(negedge clk);
        rst = r; en = e; op = o; take = t; operand = opd;
        #1;
        if (!r) chk({nm, " pc_next"}, pc_next, xpc);
        exp_q.push_back({xpc, xe, xf, xo, xu, xi});
        name_q.push_back(nm);
    endtask

    initial begin : monitor
        logic [EW-1:0] x;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, " pcOut"}, pcOut, x[EW-1:5]);
                chk({nm, " ras_empty"}, W'(ras_empty), W'(x[4]));
                chk({nm, " ras_full"}, W'(ras_full), W'(x[3]));
                chk({nm, " ras_ovf"}, W'(ras_ovf), W'(x[2]));
                chk({nm, " ras_unf"}, W'(ras_unf), W'(x[1]));
                chk({nm, " illegal_op"}, W'(illegal_op), W'(x[0]));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int wait_cycles;
        // reset and sequential stepping from RESET_VECTOR
        drive(1, 0, 3'b000, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, "reset");
        drive(0, 1, 3'b000, 0, 32'h0, 32'h1, 1, 0, 0, 0, 0, "seq1");
        drive(0, 1, 3'b000, 0, 32'h0, 32'h2, 1, 0, 0, 0, 0, "seq2");
        drive(0, 1, 3'b000, 0, 32'h0, 32'h3, 1, 0, 0, 0, 0, "seq3");
        // branches with a negative offset
        drive(0, 1, 3'b010, 0, 32'h10, 32'h10, 1, 0, 0, 0, 0, "jmp10");
        drive(0, 1, 3'b001, 1, 32'hFFFFFFFC, 32'h0C, 1, 0, 0, 0, 0, "br_taken");
        drive(0, 1, 3'b010, 0, 32'h10, 32'h10, 1, 0, 0, 0, 0, "jmp10b");
        drive(0, 1, 3'b001, 0, 32'hFFFFFFFC, 32'h11, 1, 0, 0, 0, 0, "br_not_taken");
        // wraparound
        drive(0, 1, 3'b010, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0, 0, 0, "jmp_max");
        drive(0, 1, 3'b000, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, "seq_wrap");
        // stack fill, overwrite, drain, underflow
        drive(0, 1, 3'b010, 0, 32'h100, 32'h100, 1, 0, 0, 0, 0, "jmp100");
        drive(0, 1, 3'b011, 0, 32'h200, 32'h200, 0, 0, 0, 0, 0, "call1");
        drive(0, 1, 3'b011, 0, 32'h300, 32'h300, 0, 0, 0, 0, 0, "call2");
        drive(0, 1, 3'b011, 0, 32'h400, 32'h400, 0, 0, 0, 0, 0, "call3");
        drive(0, 1, 3'b011, 0, 32'h500, 32'h500, 0, 1, 0, 0, 0, "call4");
        drive(0, 1, 3'b011, 0, 32'h600, 32'h600, 0, 1, 1, 0, 0, "call5_ovf");
        drive(0, 1, 3'b100, 0, 32'h0, 32'h501, 0, 0, 0, 0, 0, "ret1");
        drive(0, 1, 3'b100, 0, 32'h0, 32'h401, 0, 0, 0, 0, 0, "ret2");
        drive(0, 1, 3'b100, 0, 32'h0, 32'h301, 0, 0, 0, 0, 0, "ret3");
        drive(0, 1, 3'b100, 0, 32'h0, 32'h201, 1, 0, 0, 0, 0, "ret4");
        drive(0, 1, 3'b100, 0, 32'h0, 32'h202, 1, 0, 0, 1, 0, "ret5_unf");
        // illegal op behaves as SEQ; en=0 holds and clears pulses
        drive(0, 1, 3'b101, 0, 32'h0, 32'h203, 1, 0, 0, 0, 1, "illegal101");
        drive(0, 1, 3'b111, 0, 32'h0, 32'h204, 1, 0, 0, 0, 1, "illegal111");
        drive(0, 0, 3'b100, 1, 32'h55, 32'h204, 1, 0, 0, 0, 0, "hold_en0");
        // call/return with and without an idle cycle between
        drive(0, 1, 3'b010, 0, 32'h8, 32'h8, 1, 0, 0, 0, 0, "jmp8");
        drive(0, 1, 3'b011, 0, 32'h40, 32'h40, 0, 0, 0, 0, 0, "call40");
        drive(0, 0, 3'b011, 0, 32'h77, 32'h40, 0, 0, 0, 0, 0, "hold_call");
        drive(0, 1, 3'b100, 0, 32'h0, 32'h9, 1, 0, 0, 0, 0, "ret9");
        drive(0, 1, 3'b011, 0, 32'h40, 32'h40, 0, 0, 0, 0, 0, "call40b");
        drive(0, 1, 3'b100, 0, 32'h0, 32'hA, 1, 0, 0, 0, 0, "ret_b2b");
        // reset beats a CALL at occupancy 2 and discards the stack
        drive(0, 1, 3'b011, 0, 32'h70, 32'h70, 0, 0, 0, 0, 0, "call70");
        drive(0, 1, 3'b011, 0, 32'h80, 32'h80, 0, 0, 0, 0, 0, "call80");
        drive(1, 1, 3'b011, 0, 32'h90, 32'h0, 1, 0, 0, 0, 0, "rst_over_call");
        drive(0, 1, 3'b100, 0, 32'h0, 32'h1, 1, 0, 0, 1, 0, "ret_after_rst");
        drive(0, 0, 3'b000, 0, 32'h0, 32'h1, 1, 0, 0, 0, 0, "idle_end");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
